// File: rtl/uart_tx_buffered_if.sv
// Write-side bus of the buffered UART transmitter: one byte per strobed cycle
// arriving from the memory controller's UART store decode.
interface uart_tx_buffered_if;
  logic       uart_wr_i;
  logic [7:0] uart_dat_i;

  modport master (
    output uart_wr_i,
    output uart_dat_i
  );

  modport slave (
    input uart_wr_i,
    input uart_dat_i
  );
endinterface

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte stores are queued in a synchronous FIFO
// and serialised LSB-first on a registered, idle-high uart_tx line.
module uart_tx_buffered #(
  parameter int CLK_HZ     = 27000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  uart_tx_buffered_if.slave             wr_bus,
  output logic                          uart_tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_full,
  output logic                          overflow
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W        = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] BAUD_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] baud_cnt, baud_next;
  logic [2:0]       bit_idx, bit_next;
  logic [7:0]       shifter, shift_next;
  logic             tx_reg, tx_next;

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count_q, count_next;
  logic             overflow_q;
  logic [7:0]       mem [FIFO_DEPTH];

  logic             wr_accept;
  logic             wr_drop;
  logic             pop;
  logic             bit_done;

  assign fifo_count = count_q;
  assign fifo_full  = (count_q == FULL_COUNT);
  assign overflow   = overflow_q;
  assign uart_tx    = tx_reg;
  assign tx_busy    = (state != IDLE);

  // Full is judged on the registered count, so a same-cycle pop never rescues a write.
  always_comb begin
    wr_accept = wr_bus.uart_wr_i && !fifo_full;
    wr_drop   = wr_bus.uart_wr_i && fifo_full;
    pop       = (state == IDLE) && (count_q != '0);
    bit_done  = (baud_cnt == BAUD_LAST);
  end

  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    shift_next = shifter;
    tx_next    = 1'b1;
    count_next = count_q;

    case (state)
      IDLE: begin
        baud_next = '0;
        if (pop) begin
          shift_next = mem[rd_ptr];
          state_next = START;
        end
      end
      START: begin
        if (bit_done) begin
          baud_next  = '0;
          bit_next   = 3'd0;
          state_next = DATA;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_done) begin
          baud_next  = '0;
          shift_next = {1'b0, shifter[7:1]};
          bit_next   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_done) begin
          baud_next  = '0;
          state_next = IDLE;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      default: begin
        baud_next  = '0;
        state_next = IDLE;
      end
    endcase

    // The line level is decided from the upcoming state so uart_tx stays a pure flop.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase

    case ({wr_accept, pop})
      2'b10:   count_next = count_q + 1'b1;
      2'b01:   count_next = count_q - 1'b1;
      default: count_next = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= 3'd0;
      shifter    <= 8'h00;
      tx_reg     <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      shifter  <= shift_next;
      tx_reg   <= tx_next;
      count_q  <= count_next;
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Storage has no reset; a write arriving on a reset edge must not land in it.
  always_ff @(posedge clk) begin
    if (reset && wr_accept) begin
      mem[wr_ptr] <= wr_bus.uart_dat_i;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered at 8 clocks per bit; a line monitor
// decodes frames into a queue that the scenario tasks compare against.
module tb_uart_tx_buffered;

  localparam int CPB = 8;

  logic       clk;
  logic       reset;
  logic       uart_tx;
  logic       tx_busy;
  logic [4:0] fifo_count;
  logic       fifo_full;
  logic       overflow;

  int tests_run    = 0;
  int tests_failed = 0;

  uart_tx_buffered_if bus ();

  uart_tx_buffered #(
    .CLK_HZ(8),
    .BAUD(1),
    .FIFO_DEPTH(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_bus(bus),
    .uart_tx(uart_tx),
    .tx_busy(tx_busy),
    .fifo_count(fifo_count),
    .fifo_full(fifo_full),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Receiver model: detects the start bit, samples each data bit at mid-cell.
  logic [7:0] rx_q[$];
  int         start_q[$];
  logic       mon_active = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_sh = 8'h00;
  int         frame_err = 0;

  always @(negedge clk) begin
    if (!reset) begin
      mon_active <= 1'b0;
      mon_cnt    <= 0;
    end else if (!mon_active) begin
      if (uart_tx == 1'b0) begin
        mon_active <= 1'b1;
        mon_cnt    <= 1;
        start_q.push_back(cyc);
      end
    end else begin
      mon_cnt <= mon_cnt + 1;
      if ((mon_cnt % CPB) == CPB / 2 && mon_cnt >= CPB && mon_cnt < 9 * CPB)
        mon_sh <= {uart_tx, mon_sh[7:1]};
      if (mon_cnt == 10 * CPB - 1) begin
        mon_active <= 1'b0;
        rx_q.push_back(mon_sh);
        if (uart_tx !== 1'b1) frame_err <= frame_err + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rx(input int n, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (rx_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (tx_busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset          = 1'b0;
    bus.uart_wr_i  = 1'b1;
    bus.uart_dat_i = 8'hAA;
    repeat (3) tick();
    tests_run++;
    if (uart_tx !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_tx: got %b, want 1", uart_tx);
    end
    tests_run++;
    if (fifo_count !== 5'd0 || fifo_full !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_fifo: count %0d full %b, want 0 0", fifo_count, fifo_full);
    end
    tests_run++;
    if (overflow !== 1'b0 || tx_busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: overflow %b busy %b, want 0 0", overflow, tx_busy);
    end
    reset         = 1'b1;
    bus.uart_wr_i = 1'b0;
    tick();
    tests_run++;
    if (fifo_count !== 5'd0 || tx_busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_write_ignored: count %0d busy %b, want 0 0", fifo_count, tx_busy);
    end
  endtask

  task automatic test_single_byte();
    logic [7:0] b;
    logic       exp;
    int         bad;
    b   = 8'h55;
    bad = 0;
    rx_q.delete();
    bus.uart_wr_i  = 1'b1;
    bus.uart_dat_i = b;
    tick();
    bus.uart_wr_i = 1'b0;
    tests_run++;
    if (fifo_count !== 5'd1 || uart_tx !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL single_queued: count %0d tx %b, want 1 1", fifo_count, uart_tx);
    end
    tick();
    tests_run++;
    if (tx_busy !== 1'b1 || fifo_count !== 5'd0) begin
      tests_failed++;
      $display("[TB] FAIL single_pop: busy %b count %0d, want 1 0", tx_busy, fifo_count);
    end
    for (int k = 0; k < 10 * CPB; k++) begin
      if (k < CPB) exp = 1'b0;
      else if (k < 9 * CPB) exp = b[(k - CPB) / CPB];
      else exp = 1'b1;
      if (uart_tx !== exp) bad++;
      if (k < 10 * CPB - 1) tick();
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL single_bits: %0d wrong cycles, want 0", bad);
    end
    tests_run++;
    if (tx_busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL single_busy_stop: got %b, want 1", tx_busy);
    end
    tick();
    tests_run++;
    if (tx_busy !== 1'b0 || uart_tx !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL single_idle: busy %b tx %b, want 0 1", tx_busy, uart_tx);
    end
    tests_run++;
    if (rx_q.size() != 1 || rx_q[0] !== b) begin
      tests_failed++;
      $display("[TB] FAIL single_rx: %0d frames first %h, want 1 frame 55",
               rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
  endtask

  task automatic test_fill_overflow();
    bit ok;
    int bad;
    rx_q.delete();
    for (int i = 0; i < 18; i++) begin
      bus.uart_wr_i  = 1'b1;
      bus.uart_dat_i = 8'(i);
      tick();
      if (i == 0) begin
        tests_run++;
        if (fifo_count !== 5'd1) begin
          tests_failed++;
          $display("[TB] FAIL fill_first: count %0d, want 1", fifo_count);
        end
      end
      if (i == 1) begin
        tests_run++;
        if (fifo_count !== 5'd1 || tx_busy !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL fill_second: count %0d busy %b, want 1 1", fifo_count, tx_busy);
        end
      end
      if (i == 16) begin
        tests_run++;
        if (fifo_count !== 5'd16 || fifo_full !== 1'b1 || overflow !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL fill_full: count %0d full %b ovf %b, want 16 1 0",
                   fifo_count, fifo_full, overflow);
        end
      end
      if (i == 17) begin
        tests_run++;
        if (fifo_count !== 5'd16 || overflow !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL fill_overflow: count %0d ovf %b, want 16 1", fifo_count, overflow);
        end
      end
    end
    bus.uart_wr_i = 1'b0;
    wait_rx(17, 2000, ok);
    wait_idle(200, ok);
    repeat (2 * CPB) tick();
    bad = 0;
    for (int j = 0; j < 17 && j < rx_q.size(); j++)
      if (rx_q[j] !== 8'(j)) bad++;
    tests_run++;
    if (rx_q.size() != 17 || bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL fill_rx: %0d frames %0d wrong, want 17 frames 0 wrong", rx_q.size(), bad);
    end
    tests_run++;
    if (fifo_count !== 5'd0 || tx_busy !== 1'b0 || overflow !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL fill_drained: count %0d busy %b ovf %b, want 0 0 1",
               fifo_count, tx_busy, overflow);
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp_q[$];
    bit ok;
    int bad;
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hA5};
    rx_q.delete();
    for (int i = 1; i <= 4; i++) begin
      bus.uart_wr_i  = 1'b1;
      bus.uart_dat_i = 8'(i);
      tick();
    end
    bus.uart_wr_i = 1'b0;
    wait_idle(200, ok);
    tests_run++;
    if (!ok || fifo_count !== 5'd3) begin
      tests_failed++;
      $display("[TB] FAIL simul_pre: idle %b count %0d, want 1 3", ok, fifo_count);
    end
    bus.uart_wr_i  = 1'b1;
    bus.uart_dat_i = 8'hA5;
    tick();
    bus.uart_wr_i = 1'b0;
    tests_run++;
    if (fifo_count !== 5'd3 || tx_busy !== 1'b1 || uart_tx !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL simul_count: count %0d busy %b tx %b, want 3 1 0",
               fifo_count, tx_busy, uart_tx);
    end
    wait_rx(5, 1000, ok);
    bad = 0;
    for (int j = 0; j < 5 && j < rx_q.size(); j++)
      if (rx_q[j] !== exp_q[j]) bad++;
    tests_run++;
    if (rx_q.size() != 5 || bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL simul_order: %0d frames %0d wrong, want 5 frames 0 wrong", rx_q.size(), bad);
    end
    wait_idle(200, ok);
    tick();
  endtask

  task automatic test_back_to_back();
    bit ok;
    rx_q.delete();
    start_q.delete();
    bus.uart_wr_i  = 1'b1;
    bus.uart_dat_i = 8'h00;
    tick();
    bus.uart_dat_i = 8'hFF;
    tick();
    bus.uart_wr_i = 1'b0;
    wait_rx(2, 400, ok);
    tests_run++;
    if (start_q.size() != 2 || (start_q[1] - start_q[0]) != 10 * CPB + 1) begin
      tests_failed++;
      $display("[TB] FAIL b2b_spacing: %0d starts spacing %0d, want 2 starts spacing %0d",
               start_q.size(), (start_q.size() > 1) ? start_q[1] - start_q[0] : -1, 10 * CPB + 1);
    end
    tests_run++;
    if (rx_q.size() != 2 || rx_q[0] !== 8'h00 || rx_q[1] !== 8'hFF) begin
      tests_failed++;
      $display("[TB] FAIL b2b_data: %0d frames, want 2 frames 00 FF", rx_q.size());
    end
    tests_run++;
    if (frame_err != 0) begin
      tests_failed++;
      $display("[TB] FAIL stop_bits: %0d bad stop bits, want 0", frame_err);
    end
    wait_idle(200, ok);
    tick();
  endtask

  task automatic test_mid_frame_reset();
    bit ok;
    bus.uart_wr_i  = 1'b1;
    bus.uart_dat_i = 8'h0F;
    tick();
    bus.uart_dat_i = 8'h11;
    tick();
    bus.uart_dat_i = 8'h22;
    tick();
    bus.uart_wr_i = 1'b0;
    tests_run++;
    if (fifo_count !== 5'd2) begin
      tests_failed++;
      $display("[TB] FAIL mid_queued: count %0d, want 2", fifo_count);
    end
    repeat (33) tick();
    tests_run++;
    if (uart_tx !== 1'b1 || overflow !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL mid_bit3: tx %b ovf %b, want 1 1", uart_tx, overflow);
    end
    reset = 1'b0;
    tick();
    tests_run++;
    if (uart_tx !== 1'b1 || fifo_count !== 5'd0 || tx_busy !== 1'b0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset: tx %b count %0d busy %b ovf %b, want 1 0 0 0",
               uart_tx, fifo_count, tx_busy, overflow);
    end
    reset = 1'b1;
    tick();
    rx_q.delete();
    bus.uart_wr_i  = 1'b1;
    bus.uart_dat_i = 8'h3C;
    tick();
    bus.uart_wr_i = 1'b0;
    wait_rx(1, 200, ok);
    repeat (100) tick();
    tests_run++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h3C) begin
      tests_failed++;
      $display("[TB] FAIL mid_after: %0d frames first %h, want 1 frame 3C",
               rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_fill_overflow();
    test_simultaneous();
    test_back_to_back();
    test_mid_frame_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
